// File: rtl/bunch_strobe_seq.sv
// bunch_strobe_seq: generates a train of bunch strobes inside each store
// window. Bunch b is active for S_b <= k < S_b + no_samples, where
// S_b = b1_strobe + b*sample_spacing and k is the saturating sample index.
// All outputs are registered.
// Optional feature macro: BUNCH_STROBE_SEQ_LUTCOND_EN. When it is defined,
// lut_cond pulses at k = b2_strobe + 1 + m*sample_spacing. Otherwise lut_cond
// is tied low.
module bunch_strobe_seq #(
  parameter int CNT_W = 8,
  parameter int NB_W  = 3,
  parameter int NS_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store_strb,
  input  logic [CNT_W-1:0] b1_strobe,
  input  logic [CNT_W-1:0] b2_strobe,
  input  logic [NB_W-1:0]  no_bunches,
  input  logic [NS_W-1:0]  no_samples,
  input  logic [CNT_W-1:0] sample_spacing,
  output logic             bunch_strb,
  output logic [NB_W-1:0]  bunch_idx,
  output logic             bunch_first,
  output logic             train_done,
  output logic             cfg_err,
  output logic             lut_cond
);

  // Positions are one bit wider than CNT_W+NB_W so that S_b + no_samples
  // never wraps. A position beyond the counter range is simply never reached.
  localparam int POS_W = CNT_W + NB_W + 1;
  localparam logic [CNT_W-1:0] K_MAX = '1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == K_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [POS_W-1:0] to_pos(input logic [CNT_W-1:0] v);
    return POS_W'(v);
  endfunction

  logic [2:0]       state_q, state_n;
  logic [CNT_W-1:0] k_q, k_n;
  logic [NB_W-1:0]  bidx_n;
  logic [POS_W-1:0] s_q, s_n;
  logic [NB_W-1:0]  nb_q;
  logic [NS_W-1:0]  ns_q;
  logic [CNT_W-1:0] sp_q;
  logic             strb_n, first_n, done_n, err_n, lut_n;

  // Config is sampled on the first window edge and held for the rest of it.
  logic             first_edge;
  logic [NB_W-1:0]  cfg_nb;
  logic [NS_W-1:0]  cfg_ns;
  logic [CNT_W-1:0] cfg_sp;
  logic             cfg_bad;

  assign first_edge = (state_q == ST_IDLE);
  assign cfg_nb     = first_edge ? no_bunches     : nb_q;
  assign cfg_ns     = first_edge ? no_samples     : ns_q;
  assign cfg_sp     = first_edge ? sample_spacing : sp_q;
  assign cfg_bad    = (no_samples == '0) ||
                      ((no_bunches > NB_W'(1)) &&
                       (POS_W'(sample_spacing) < POS_W'(no_samples)));

  // Sequencer next state: evaluates the bunch windows at the new sample index.
  always_comb begin
    state_n = state_q;
    k_n     = k_q;
    bidx_n  = bunch_idx;
    s_n     = s_q;
    strb_n  = 1'b0;
    first_n = 1'b0;
    if (!store_strb) begin
      state_n = ST_IDLE;
      k_n     = '0;
      bidx_n  = '0;
    end else begin
      if (first_edge) begin
        k_n    = '0;
        bidx_n = '0;
        s_n    = to_pos(b1_strobe);
        if (cfg_bad)
          state_n = ST_ERR;
        else if (no_bunches == '0)
          state_n = ST_DONE;
        else
          state_n = ST_WAIT;
      end else begin
        k_n = sat_inc(k_q);
      end
      case (state_n)
        ST_WAIT: begin
          if (to_pos(k_n) == s_n) begin
            state_n = ST_HIGH;
            strb_n  = 1'b1;
            first_n = 1'b1;
          end
        end
        ST_HIGH: begin
          if (to_pos(k_n) == s_n + POS_W'(cfg_ns)) begin
            if (bidx_n == cfg_nb - NB_W'(1)) begin
              state_n = ST_DONE;
            end else begin
              bidx_n = bidx_n + NB_W'(1);
              s_n    = s_n + POS_W'(cfg_sp);
              // spacing == width: the next bunch starts on this same sample
              if (to_pos(k_n) == s_n) begin
                strb_n  = 1'b1;
                first_n = 1'b1;
              end else begin
                state_n = ST_WAIT;
              end
            end
          end else begin
            strb_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
    done_n = store_strb && (state_n == ST_DONE);
    err_n  = store_strb && (state_n == ST_ERR);
  end

`ifdef BUNCH_STROBE_SEQ_LUTCOND_EN
  logic [POS_W-1:0] l_q, l_n;
  logic [NB_W-1:0]  m_q, m_n;
  logic [NB_W-1:0]  lut_cnt;

  // LUT strobe tracker: next reference position and how many have fired.
  always_comb begin
    l_n     = l_q;
    m_n     = m_q;
    lut_n   = 1'b0;
    lut_cnt = (cfg_nb == '0) ? NB_W'(1) : cfg_nb;
    if (store_strb) begin
      if (first_edge) begin
        l_n = to_pos(b2_strobe) + POS_W'(1);
        m_n = '0;
      end
      if (state_n != ST_ERR) begin
        // A saturated index repeats the same k, so the strobe just holds.
        if (!first_edge && (k_q == K_MAX)) begin
          lut_n = lut_cond;
        end else if ((to_pos(k_n) == l_n) && (m_n < lut_cnt)) begin
          lut_n = 1'b1;
          l_n   = l_n + POS_W'(cfg_sp);
          m_n   = m_n + NB_W'(1);
        end
      end
    end
  end

  // LUT tracker position registers.
  always_ff @(posedge clk) begin
    l_q <= l_n;
    m_q <= m_n;
  end
`else
  logic unused_b2;
  assign unused_b2 = ^b2_strobe;
  assign lut_n     = 1'b0;
`endif

  // Config latch and bunch start position, captured without reset.
  always_ff @(posedge clk) begin
    if (store_strb && first_edge) begin
      nb_q <= no_bunches;
      ns_q <= no_samples;
      sp_q <= sample_spacing;
    end
    s_q <= s_n;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      bunch_strb  <= 1'b0;
      bunch_idx   <= '0;
      bunch_first <= 1'b0;
      train_done  <= 1'b0;
      cfg_err     <= 1'b0;
      lut_cond    <= 1'b0;
    end else begin
      state_q     <= state_n;
      k_q         <= k_n;
      bunch_strb  <= strb_n;
      bunch_idx   <= bidx_n;
      bunch_first <= first_n;
      train_done  <= done_n;
      cfg_err     <= err_n;
      lut_cond    <= lut_n;
    end
  end

endmodule
